// File: rtl/c4_drop_engine_if.sv
// Player move bus: one-cycle move request in, one-cycle resolution pulse out.
interface c4_drop_engine_if;
    logic       move_valid;
    logic [2:0] move_col;
    logic       move_player;
    logic       move_done;
    logic       move_ok;
    logic [2:0] move_row;

    modport master (
        output move_valid, move_col, move_player,
        input  move_done, move_ok, move_row
    );

    modport slave (
        input  move_valid, move_col, move_player,
        output move_done, move_ok, move_row
    );
endinterface

// File: rtl/c4_drop_engine.sv
// Connect-4 move validator, falling-piece sequencer and board store.
// Moves arriving while busy are dropped; the board is read combinationally.
module c4_drop_engine #(
    parameter int ROWS       = 6,
    parameter int COLS       = 7,
    parameter int DROP_TICKS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_game,
    c4_drop_engine_if.slave    mv,
    input  logic [2:0]         rd_row,
    input  logic [2:0]         rd_col,
    output logic [1:0]         rd_cell,
    output logic               cur_player,
    output logic               busy,
    output logic               fall_active,
    output logic [2:0]         fall_row,
    output logic [2:0]         fall_col,
    output logic               board_full
);
    localparam int HW    = $clog2(ROWS + 1);
    localparam int CELLS = ROWS * COLS;
    localparam int CW    = $clog2(CELLS + 1);
    localparam int TW    = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, CHECK, FALL, COMMIT} state_t;

    state_t          state, state_nxt;
    logic [1:0]      board  [ROWS][COLS];
    logic [HW-1:0]   height [COLS];
    logic [CW-1:0]   move_count;
    logic [2:0]      col_q;
    logic            player_q;
    logic [2:0]      target;
    logic [TW-1:0]   tick;
    logic [HW-1:0]   h_sel;
    logic            col_ok;
    logic            reject;
    logic            tick_end;
    logic            do_accept, do_reject, do_commit;

    // Guard the height lookup so an out-of-range column never indexes the array.
    assign col_ok = int'(col_q) < COLS;
    always_comb begin
        h_sel = '0;
        if (col_ok) h_sel = height[col_q];
    end

    assign reject   = !col_ok || (h_sel == HW'(ROWS)) || (player_q != cur_player) || board_full;
    assign tick_end = (tick == TW'(DROP_TICKS - 1));
    assign busy     = (state != IDLE);
    assign fall_active = (state == FALL) || (state == COMMIT);
    assign board_full  = (move_count == CW'(CELLS));

    always_comb begin
        rd_cell = 2'b00;
        if ((int'(rd_row) < ROWS) && (int'(rd_col) < COLS)) rd_cell = board[rd_row][rd_col];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           state <= IDLE;
        else if (new_game) state <= IDLE;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_accept = 1'b0;
        do_reject = 1'b0;
        do_commit = 1'b0;
        case (state)
            IDLE:   if (mv.move_valid) state_nxt = CHECK;
            CHECK: begin
                if (reject) begin
                    do_reject = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    do_accept = 1'b1;
                    state_nxt = FALL;
                end
            end
            FALL:   if (tick_end && (fall_row == target)) state_nxt = COMMIT;
            COMMIT: begin
                do_commit = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sequencing datapath: request latch, fall position, turn and result pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            player_q     <= 1'b0;
            target       <= '0;
            tick         <= '0;
            fall_row     <= '0;
            fall_col     <= '0;
            cur_player   <= 1'b0;
            move_count   <= '0;
            mv.move_done <= 1'b0;
            mv.move_ok   <= 1'b0;
            mv.move_row  <= '0;
        end else if (new_game) begin
            col_q        <= '0;
            player_q     <= 1'b0;
            target       <= '0;
            tick         <= '0;
            fall_row     <= '0;
            fall_col     <= '0;
            cur_player   <= 1'b0;
            move_count   <= '0;
            mv.move_done <= 1'b0;
            mv.move_ok   <= 1'b0;
            mv.move_row  <= '0;
        end else begin
            mv.move_done <= 1'b0;
            mv.move_ok   <= 1'b0;
            if ((state == IDLE) && mv.move_valid) begin
                col_q    <= mv.move_col;
                player_q <= mv.move_player;
            end
            if (do_reject) begin
                mv.move_done <= 1'b1;
            end
            if (do_accept) begin
                target   <= 3'(h_sel);
                fall_row <= 3'(ROWS - 1);
                fall_col <= col_q;
                tick     <= '0;
            end
            if (state == FALL) begin
                if (tick_end) begin
                    if (fall_row != target) begin
                        fall_row <= fall_row - 3'd1;
                        tick     <= '0;
                    end
                end else begin
                    tick <= tick + 1'b1;
                end
            end
            if (do_commit) begin
                cur_player   <= ~cur_player;
                mv.move_done <= 1'b1;
                mv.move_ok   <= 1'b1;
                mv.move_row  <= target;
                if (move_count != CW'(CELLS)) move_count <= move_count + 1'b1;
            end
        end
    end

    // Board and column heights only change on COMMIT, so an abort never leaves a partial write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    board[r][c] <= 2'b00;
            for (int c = 0; c < COLS; c++) height[c] <= '0;
        end else if (new_game) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    board[r][c] <= 2'b00;
            for (int c = 0; c < COLS; c++) height[c] <= '0;
        end else if (do_commit) begin
            board[target][col_q] <= player_q ? 2'b10 : 2'b01;
            height[col_q]        <= height[col_q] + 1'b1;
        end
    end
endmodule

// File: tb/tb_c4_drop_engine.sv
// Scoreboarded bench: DROP_TICKS=1 engine for move rules, DROP_TICKS=3 engine for aborts.
module tb_c4_drop_engine;
    localparam int ROWS = 6;
    localparam int COLS = 7;

    typedef struct {
        bit ok;
        int row;
        int due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst1, rst3, new_game1, new_game3;
    logic [2:0] rd_row1, rd_col1, rd_row3, rd_col3;
    logic [1:0] rd_cell1, rd_cell3;
    logic       cur_player1, busy1, fall_active1, board_full1;
    logic       cur_player3, busy3, fall_active3, board_full3;
    logic [2:0] fall_row1, fall_col1, fall_row3, fall_col3;

    c4_drop_engine_if mv1();
    c4_drop_engine_if mv3();

    c4_drop_engine #(.ROWS(ROWS), .COLS(COLS), .DROP_TICKS(1)) dut1 (
        .clk(clk), .rst(rst1), .new_game(new_game1), .mv(mv1.slave),
        .rd_row(rd_row1), .rd_col(rd_col1), .rd_cell(rd_cell1),
        .cur_player(cur_player1), .busy(busy1), .fall_active(fall_active1),
        .fall_row(fall_row1), .fall_col(fall_col1), .board_full(board_full1)
    );

    c4_drop_engine #(.ROWS(ROWS), .COLS(COLS), .DROP_TICKS(3)) dut3 (
        .clk(clk), .rst(rst3), .new_game(new_game3), .mv(mv3.slave),
        .rd_row(rd_row3), .rd_col(rd_col3), .rd_cell(rd_cell3),
        .cur_player(cur_player3), .busy(busy3), .fall_active(fall_active3),
        .fall_row(fall_row3), .fall_col(fall_col3), .board_full(board_full3)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   done3 = 0;
    exp_t q[$];

    int   model_h [COLS];
    int   model_board [ROWS][COLS];
    bit   model_player;
    int   model_count;

    always @(posedge clk) cyc <= cyc + 1;

    // Every move_done on the DROP_TICKS=1 engine must match the oldest expectation.
    always @(negedge clk) begin
        if (mv1.move_done === 1'b1) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: move_done at cycle %0d with no move pending", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (mv1.move_ok !== e.ok || (e.ok && mv1.move_row !== 3'(e.row)) || cyc != e.due) begin
                    fails++;
                    $display("FAIL move_result: got ok=%0b row=%0d cycle=%0d, want ok=%0b row=%0d cycle=%0d",
                             mv1.move_ok, mv1.move_row, cyc, e.ok, e.row, e.due);
                end
            end
        end
        if (mv3.move_done === 1'b1) done3++;
    end

    task automatic model_clear();
        for (int c = 0; c < COLS; c++) model_h[c] = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model_board[r][c] = 0;
        model_player = 1'b0;
        model_count  = 0;
    endtask

    task automatic check_board1(input string name);
        int bad;
        bad = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                rd_row1 = 3'(r);
                rd_col1 = 3'(c);
                #1;
                if (rd_cell1 !== 2'(model_board[r][c])) begin
                    bad++;
                    if (bad == 1)
                        $display("FAIL %s: cell(%0d,%0d) got %0d want %0d", name, r, c, rd_cell1, model_board[r][c]);
                end
            end
        end
        tests++;
        if (bad != 0) fails++;
    endtask

    // Drives one move pulse; optionally watches the fall and/or injects a second pulse while busy.
    task automatic do_move(input int col, input bit player, input bit watch, input int intrude_col);
        exp_t e;
        int   k, lat, tgt, n;
        bit   acc;
        acc = (col < COLS) && (player == model_player) && (model_count < ROWS * COLS);
        if (acc) acc = model_h[col] < ROWS;
        tgt = acc ? model_h[col] : 0;
        @(posedge clk); #1;
        k = cyc;
        mv1.move_valid  = 1'b1;
        mv1.move_col    = 3'(col);
        mv1.move_player = player;
        if (acc) begin
            lat = 3 + (ROWS - tgt);
            e = '{1'b1, tgt, k + lat};
            model_board[tgt][col] = player ? 2 : 1;
            model_h[col]++;
            model_count++;
            model_player = ~model_player;
        end else begin
            lat = 2;
            e = '{1'b0, 0, k + 2};
        end
        q.push_back(e);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk); #1;
            if (i == 1) mv1.move_valid = 1'b0;
            if (intrude_col >= 0 && i == 3) begin
                mv1.move_valid  = 1'b1;
                mv1.move_col    = 3'(intrude_col);
                mv1.move_player = model_player;
            end
            if (intrude_col >= 0 && i == 4) mv1.move_valid = 1'b0;
            if (watch && acc && i >= 2 && i < 2 + ROWS - tgt) begin
                tests++;
                if (fall_active1 !== 1'b1 || fall_row1 !== 3'(ROWS - 1 - (i - 2)) || fall_col1 !== 3'(col)) begin
                    fails++;
                    $display("FAIL fall_step: T+%0d active=%0b row=%0d col=%0d, want active=1 row=%0d col=%0d",
                             i, fall_active1, fall_row1, fall_col1, ROWS - 1 - (i - 2), col);
                end
            end
        end
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL move_timeout: no move_done for col %0d after %0d cycles", col, n + lat);
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1;
        rst3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({cur_player1, busy1, fall_active1, mv1.move_done, mv1.move_ok, board_full1,
             fall_row1, fall_col1, mv1.move_row} !== 15'd0) begin
            fails++;
            $display("FAIL reset_outputs: cp=%0b busy=%0b fa=%0b done=%0b ok=%0b full=%0b fr=%0d fc=%0d mr=%0d, want all 0",
                     cur_player1, busy1, fall_active1, mv1.move_done, mv1.move_ok, board_full1,
                     fall_row1, fall_col1, mv1.move_row);
        end
        model_clear();
        check_board1("reset_board");
        rd_row1 = 3'd7;
        rd_col1 = 3'd0;
        #1;
        tests++;
        if (rd_cell1 !== 2'b00) begin
            fails++;
            $display("FAIL rd_out_of_range: got %0d want 0", rd_cell1);
        end
    endtask

    task automatic test_single_drop();
        do_move(3, 1'b0, 1'b1, -1);
        rd_row1 = 3'd0;
        rd_col1 = 3'd3;
        #1;
        tests++;
        if (rd_cell1 !== 2'b01 || cur_player1 !== 1'b1) begin
            fails++;
            $display("FAIL single_drop: cell(0,3)=%0d cur_player=%0b, want 1 and 1", rd_cell1, cur_player1);
        end
    endtask

    task automatic test_column_full();
        for (int i = 0; i < 7; i++) do_move(2, model_player, 1'b0, -1);
        check_board1("column_full_board");
        tests++;
        if (cur_player1 !== model_player) begin
            fails++;
            $display("FAIL column_full_turn: got %0b want %0b", cur_player1, model_player);
        end
    endtask

    task automatic test_rejects();
        do_move(7, model_player, 1'b0, -1);
        do_move(0, ~model_player, 1'b0, -1);
        tests++;
        if (cur_player1 !== model_player) begin
            fails++;
            $display("FAIL reject_turn: got %0b want %0b", cur_player1, model_player);
        end
        check_board1("reject_board");
    endtask

    task automatic test_busy_ignore();
        do_move(4, model_player, 1'b0, 5);
        repeat (15) @(posedge clk);
        #1;
        check_board1("busy_ignore_board");
    endtask

    task automatic test_fill();
        @(posedge clk); #1;
        new_game1 = 1'b1;
        @(posedge clk); #1;
        new_game1 = 1'b0;
        model_clear();
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                do_move(c, model_player, 1'b0, -1);
        #1;
        tests++;
        if (board_full1 !== 1'b1) begin
            fails++;
            $display("FAIL board_full: got %0b want 1", board_full1);
        end
        do_move(0, model_player, 1'b0, -1);
        check_board1("full_board");
        @(posedge clk); #1;
        new_game1 = 1'b1;
        @(posedge clk); #1;
        new_game1 = 1'b0;
        model_clear();
        tests++;
        if (board_full1 !== 1'b0 || cur_player1 !== 1'b0) begin
            fails++;
            $display("FAIL new_game: full=%0b cur_player=%0b, want 0 and 0", board_full1, cur_player1);
        end
        check_board1("new_game_board");
    endtask

    task automatic pulse_move3(input int col);
        @(posedge clk); #1;
        mv3.move_valid  = 1'b1;
        mv3.move_col    = 3'(col);
        mv3.move_player = 1'b0;
        @(posedge clk); #1;
        mv3.move_valid  = 1'b0;
    endtask

    task automatic test_abort();
        done3 = 0;
        pulse_move3(1);
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (fall_active3 !== 1'b1) begin
            fails++;
            $display("FAIL abort_setup: fall_active=%0b want 1", fall_active3);
        end
        @(posedge clk); #2;
        rst3 = 1'b1;
        #1;
        tests++;
        if ({busy3, fall_active3, fall_row3, fall_col3, cur_player3, mv3.move_done, mv3.move_ok,
             mv3.move_row, board_full3} !== 14'd0) begin
            fails++;
            $display("FAIL rst_mid_fall: busy=%0b fa=%0b fr=%0d fc=%0d cp=%0b, want all 0",
                     busy3, fall_active3, fall_row3, fall_col3, cur_player3);
        end
        @(posedge clk); #1;
        rst3 = 1'b0;
        rd_row3 = 3'd0;
        rd_col3 = 3'd1;
        repeat (30) @(posedge clk);
        #1;
        tests++;
        if (rd_cell3 !== 2'b00 || done3 != 0 || busy3 !== 1'b0) begin
            fails++;
            $display("FAIL rst_abort_result: cell=%0d done_count=%0d busy=%0b, want 0 0 0", rd_cell3, done3, busy3);
        end
        pulse_move3(1);
        repeat (5) @(posedge clk);
        #1;
        new_game3 = 1'b1;
        @(posedge clk); #1;
        new_game3 = 1'b0;
        tests++;
        if (busy3 !== 1'b0 || fall_active3 !== 1'b0 || fall_row3 !== 3'd0) begin
            fails++;
            $display("FAIL new_game_mid_fall: busy=%0b fa=%0b fr=%0d, want 0 0 0", busy3, fall_active3, fall_row3);
        end
        repeat (30) @(posedge clk);
        #1;
        tests++;
        if (rd_cell3 !== 2'b00 || done3 != 0 || cur_player3 !== 1'b0) begin
            fails++;
            $display("FAIL new_game_abort_result: cell=%0d done_count=%0d cp=%0b, want 0 0 0", rd_cell3, done3, cur_player3);
        end
    endtask

    initial begin
        rst1 = 1'b1;
        rst3 = 1'b1;
        new_game1 = 1'b0;
        new_game3 = 1'b0;
        mv1.move_valid = 1'b0;
        mv1.move_col = 3'd0;
        mv1.move_player = 1'b0;
        mv3.move_valid = 1'b0;
        mv3.move_col = 3'd0;
        mv3.move_player = 1'b0;
        rd_row1 = 3'd0;
        rd_col1 = 3'd0;
        rd_row3 = 3'd0;
        rd_col3 = 3'd0;
        test_reset();
        test_single_drop();
        test_column_full();
        test_rejects();
        test_busy_ignore();
        test_fill();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
